// File: rtl/io_pwm_pkg.sv
// Register map, field positions and address decode shared by the PWM block and its channels.
package io_pwm_pkg;

    localparam logic [3:0] OFS_CTRL     = 4'd0;
    localparam logic [3:0] OFS_PRESCALE = 4'd1;
    localparam logic [3:0] OFS_PERIOD   = 4'd2;
    localparam logic [3:0] OFS_STATUS   = 4'd3;
    localparam logic [3:0] OFS_DUTY0    = 4'd4;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STATUS_WRAP_BIT = 0;

    typedef struct packed {
        logic       hit;
        logic [3:0] ofs;
    } reg_dec_t;

    // A 16-word window starting at base; works for unaligned bases too.
    function automatic reg_dec_t decode_adr(input logic [13:0] adr, input logic [13:0] base);
        logic [13:0] diff;
        diff           = adr - base;
        decode_adr.hit = (diff[13:4] == 10'd0);
        decode_adr.ofs = diff[3:0];
    endfunction

endpackage

// File: rtl/io_pwm_chan.sv
// One PWM channel: programmed duty, period-aligned shadow copy, compare and output flop.
module io_pwm_chan #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             wrap_i,
    input  logic             duty_we_i,
    input  logic [CNT_W-1:0] wdata_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [CNT_W-1:0] duty_o,
    output logic             pwm_o
);

    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        duty_d     = duty_we_i ? wdata_i : duty_q;
        duty_act_d = duty_act_q;
        // Idle channels track the programmed value so enabling starts with fresh settings.
        if (!enable_i) begin
            duty_act_d = duty_d;
        end else if (wrap_i) begin
            duty_act_d = duty_q;
        end
        pwm_d = enable_i && (cnt_i < duty_act_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_q     <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            duty_q     <= duty_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign duty_o = duty_d;
    assign pwm_o  = pwm_q;

endmodule

// File: rtl/io_pwm_multi.sv
// Multi-channel PWM with shared prescaler/period counter and a daisy-chained register read port.
module io_pwm_multi
    import io_pwm_pkg::*;
#(
    parameter int          NCH      = 4,
    parameter int          CNT_W    = 16,
    parameter logic [13:0] BASE_ADR = 14'h3100
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           dma_io_we,
    input  logic [15:2]    dma_io_wadr,
    input  logic [31:0]    dma_io_wdata,
    input  logic [15:2]    dma_io_radr,
    input  logic           dma_io_radr_en,
    input  logic [31:0]    dma_io_rdata_in,
    output logic [31:0]    dma_io_rdata,
    output logic [NCH-1:0] pwm_out,
    output logic           pwm_irq
);

    reg_dec_t         wdec, rdec;
    logic             wr_hit, enable, tick, wrap;
    logic [CNT_W-1:0] wdata_trunc;
    logic [CNT_W-1:0] duty_rd [NCH];
    logic [31:0]      rd_val;

    logic [1:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] prescale_q, prescale_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] period_act_q, period_act_d;
    logic             status_q, status_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_vld_q, rd_vld_d;
    logic [31:0]      rd_data_q, rd_data_d;

    assign wdec        = decode_adr(dma_io_wadr, BASE_ADR);
    assign rdec        = decode_adr(dma_io_radr, BASE_ADR);
    assign wr_hit      = dma_io_we && wdec.hit;
    assign wdata_trunc = dma_io_wdata[CNT_W-1:0];
    assign enable      = ctrl_q[CTRL_EN_BIT];
    assign tick        = enable && (presc_q == prescale_q);
    assign wrap        = tick && (cnt_q == period_act_q);

    generate
        if (CNT_W < 32) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^dma_io_wdata[31:CNT_W];
        end
    endgenerate

    always_comb begin
        ctrl_d     = (wr_hit && wdec.ofs == OFS_CTRL)     ? dma_io_wdata[1:0] : ctrl_q;
        prescale_d = (wr_hit && wdec.ofs == OFS_PRESCALE) ? wdata_trunc       : prescale_q;
        period_d   = (wr_hit && wdec.ofs == OFS_PERIOD)   ? wdata_trunc       : period_q;

        // A wrap in the same cycle as a clear keeps the flag set.
        status_d = status_q;
        if (wrap) begin
            status_d = 1'b1;
        end else if (wr_hit && wdec.ofs == OFS_STATUS && dma_io_wdata[STATUS_WRAP_BIT]) begin
            status_d = 1'b0;
        end

        period_act_d = period_act_q;
        if (!enable) begin
            period_act_d = period_d;
        end else if (wrap) begin
            period_act_d = period_q;
        end

        presc_d = (!enable || tick) ? '0 : presc_q + CNT_W'(1);
        cnt_d   = cnt_q;
        if (!enable || wrap) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Read mux uses next-state values so a same-cycle write is returned.
    always_comb begin
        rd_val = 32'd0;
        case (rdec.ofs)
            OFS_CTRL:     rd_val = 32'(ctrl_d);
            OFS_PRESCALE: rd_val = 32'(prescale_d);
            OFS_PERIOD:   rd_val = 32'(period_d);
            OFS_STATUS:   rd_val = 32'(status_d);
            default: begin
                for (int ch = 0; ch < NCH; ch++) begin
                    if (rdec.ofs == OFS_DUTY0 + 4'(ch)) begin
                        rd_val = 32'(duty_rd[ch]);
                    end
                end
            end
        endcase
        rd_vld_d  = dma_io_radr_en && rdec.hit;
        rd_data_d = rd_vld_d ? rd_val : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q       <= '0;
            prescale_q   <= '0;
            period_q     <= '1;
            period_act_q <= '1;
            status_q     <= 1'b0;
            presc_q      <= '0;
            cnt_q        <= '0;
            rd_vld_q     <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            prescale_q   <= prescale_d;
            period_q     <= period_d;
            period_act_q <= period_act_d;
            status_q     <= status_d;
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
            rd_vld_q     <= rd_vld_d;
            rd_data_q    <= rd_data_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic duty_we;
            assign duty_we = wr_hit && (wdec.ofs == OFS_DUTY0 + 4'(gi));

            io_pwm_chan #(
                .CNT_W(CNT_W)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .enable_i  (enable),
                .wrap_i    (wrap),
                .duty_we_i (duty_we),
                .wdata_i   (wdata_trunc),
                .cnt_i     (cnt_q),
                .duty_o    (duty_rd[gi]),
                .pwm_o     (pwm_out[gi])
            );
        end
    endgenerate

    assign dma_io_rdata = rd_vld_q ? rd_data_q : dma_io_rdata_in;
    assign pwm_irq      = status_q & ctrl_q[CTRL_IRQ_EN_BIT];

endmodule

// File: tb/tb_io_pwm_multi.sv
// Directed bench for io_pwm_multi: register access, PWM waveforms, shadow timing, irq and reset.
module tb_io_pwm_multi;

    localparam logic [13:0] BASE = 14'h3100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [15:2] wadr;
    logic [31:0] wdata;
    logic [15:2] radr;
    logic        radr_en;
    logic [31:0] rdata_in;
    logic [31:0] rdata;
    logic [3:0]  pwm_out;
    logic        pwm_irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    io_pwm_multi #(
        .NCH      (4),
        .CNT_W    (16),
        .BASE_ADR (BASE)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dma_io_we       (we),
        .dma_io_wadr     (wadr),
        .dma_io_wdata    (wdata),
        .dma_io_radr     (radr),
        .dma_io_radr_en  (radr_en),
        .dma_io_rdata_in (rdata_in),
        .dma_io_rdata    (rdata),
        .pwm_out         (pwm_out),
        .pwm_irq         (pwm_irq)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%08h exp=0x%08h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] ofs, input logic [31:0] d);
        we    = 1'b1;
        wadr  = BASE + 14'(ofs);
        wdata = d;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        $display("wr ofs=%0d data=0x%08h", ofs, d);
    endtask

    task automatic rd(input string tag, input logic [13:0] adr, input logic [31:0] exp);
        radr    = adr;
        radr_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        radr_en = 1'b0;
        $display("rd adr=0x%04h data=0x%08h", adr, rdata);
        chk(tag, rdata, exp);
    endtask

    initial begin
        int         c;
        int         d;
        logic [3:0] exp_pwm;
        logic       exp_irq;

        rst_n    = 1'b0;
        we       = 1'b0;
        wadr     = '0;
        wdata    = '0;
        radr     = '0;
        radr_en  = 1'b0;
        rdata_in = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_irq", 32'(pwm_irq), 32'd0);
        chk("rst_rdata_pass", rdata, 32'hDEADBEEF);
        rst_n = 1'b1;
        @(negedge clk);

        rd("rd_period_rst", BASE + 14'd2, 32'h0000FFFF);
        @(negedge clk);
        chk("rd_idle_pass", rdata, 32'hDEADBEEF);
        rdata_in = 32'h12345678;
        #1;
        chk("rd_pass_comb", rdata, 32'h12345678);
        rd("rd_miss_above", BASE + 14'd16, 32'h12345678);
        rd("rd_miss_below", BASE - 14'd1, 32'h12345678);

        wr(4'd2, 32'hFFFF0009);
        rd("rd_period_trunc", BASE + 14'd2, 32'h00000009);
        wr(4'd4, 32'd3);
        wr(4'd5, 32'd0);
        wr(4'd6, 32'd20);
        wr(4'd1, 32'd0);
        wr(4'd9, 32'h0000ABCD);
        rd("rd_unused_ofs", BASE + 14'd9, 32'd0);
        rd("rd_duty2", BASE + 14'd6, 32'd20);
        rd("rd_ctrl_idle", BASE + 14'd0, 32'd0);

        // Enable with irq; this sample is j=0 and the counter sits at 0.
        wr(4'd0, 32'd3);
        chk("en_pwm_j0", 32'(pwm_out), 32'd0);
        chk("en_irq_j0", 32'(pwm_irq), 32'd0);

        for (int j = 1; j <= 40; j++) begin
            @(posedge clk);
            @(negedge clk);
            we      = 1'b0;
            radr_en = 1'b0;
            c       = (j - 1) % 10;
            d       = ((j - 1) < 30) ? 3 : 6;
            exp_pwm = {1'b0, 1'b1, 1'b0, (c < d)};
            exp_irq = (j >= 10 && j <= 20) || (j >= 30);
            $display("cyc j=%0d pwm=%b irq=%b", j, pwm_out, pwm_irq);
            chk($sformatf("pwm_j%0d", j), 32'(pwm_out), 32'(exp_pwm));
            chk($sformatf("irq_j%0d", j), 32'(pwm_irq), 32'(exp_irq));
            if (j == 23) begin
                chk("rd_duty0_wprio", rdata, 32'd6);
            end
            if (j == 20 || j == 29) begin
                we    = 1'b1;
                wadr  = BASE + 14'd3;
                wdata = 32'd1;
            end
            if (j == 22) begin
                we      = 1'b1;
                wadr    = BASE + 14'd4;
                wdata   = 32'd6;
                radr    = BASE + 14'd4;
                radr_en = 1'b1;
            end
        end

        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid_period_pwm", 32'(pwm_out), 32'b0101);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_pwm", 32'(pwm_out), 32'd0);
        chk("midrst_irq", 32'(pwm_irq), 32'd0);
        chk("midrst_rdata_pass", rdata, 32'h12345678);
        rd("midrst_ctrl", BASE + 14'd0, 32'd0);
        rd("midrst_period", BASE + 14'd2, 32'h0000FFFF);
        rd("midrst_duty0", BASE + 14'd4, 32'd0);
        rd("midrst_duty2", BASE + 14'd6, 32'd0);
        rd("midrst_status", BASE + 14'd3, 32'd0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("post_rst_pwm_idle", 32'(pwm_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_pwm_multi.md
IO_PWM_MULTI -- requirements
Module: io_pwm_multi

Interface
REQ-001 SHALL have parameter NCH, default 4, number of PWM channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16, counter/period/duty width (8..32).
REQ-003 SHALL have parameter BASE_ADR, default 14'h3100, word address of register 0 on dma_io bus.
REQ-004 SHALL have port clk input 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n input 1, synchronous active-low reset.
REQ-006 SHALL have ports dma_io_we input 1 / dma_io_wadr input [15:2] / dma_io_wdata input 32, single-cycle register write.
REQ-007 SHALL have ports dma_io_radr input [15:2] / dma_io_radr_en input 1, read request.
REQ-008 SHALL have port dma_io_rdata_in input 32, upstream read data of daisy chain.
REQ-009 SHALL have port dma_io_rdata output 32, read data to downstream chain element.
REQ-010 SHALL have port pwm_out output NCH, registered PWM outputs.
REQ-011 SHALL have port pwm_irq output 1, level interrupt.

Function
REQ-012 SHALL decode word offsets from BASE_ADR: 0 CTRL (b0 enable, b1 irq_en), 1 PRESCALE, 2 PERIOD, 3 STATUS (b0 wrap flag, write-1-clear), 4+ch DUTY[ch].
REQ-013 SHALL ignore writes to offsets 4+NCH..15; reads of those offsets SHALL return 0; addresses outside BASE_ADR..BASE_ADR+15 SHALL not hit.
REQ-014 SHALL register read hit: cycle after dma_io_radr_en with hit, dma_io_rdata = register value zero-extended; all other cycles dma_io_rdata = dma_io_rdata_in combinationally.
REQ-015 SHALL run prescaler 0..PRESCALE[CNT_W-1:0]; tick asserted in cycle prescaler == PRESCALE, prescaler then reloads 0 (PRESCALE=0 -> tick every cycle).
REQ-016 SHALL advance counter cnt by 1 on each tick; at tick with cnt == period_act, cnt wraps to 0 (period length period_act+1 ticks).
REQ-017 SHALL load shadow period_act and duty_act[ch] from programmed registers only on wrap, so mid-period writes take effect at next period start, glitch-free.
REQ-018 SHALL drive pwm_out[ch] <= enable && (cnt < duty_act[ch]), one-cycle register latency; duty 0 -> constant low; duty > period_act -> constant high.
REQ-019 SHALL set STATUS.b0 on each wrap; write-1 to b0 clears; simultaneous wrap and clear -> flag stays set.
REQ-020 SHALL drive pwm_irq = STATUS.b0 & CTRL.b1, combinational from registers.
REQ-021 SHALL, while CTRL.b0 = 0, hold prescaler and cnt at 0, pwm_out low, and shadows continuously equal to programmed values; on enable 0->1 first period starts with cnt = 0 using current values.
REQ-022 SHALL truncate all arithmetic to CNT_W bits; wdata bits above CNT_W ignored; counter never exceeds period_act.
REQ-023 SHALL give write priority to same-cycle read of same register: read returns new value next cycle.

Reset
REQ-024 SHALL on rst_n low at clk edge: CTRL 0, PRESCALE 0, PERIOD all-ones, DUTY 0, STATUS 0, shadows equal to these, prescaler/cnt 0, pwm_out 0, read register 0.
REQ-025 SHALL abort any period on mid-operation reset; first period after release obeys REQ-021.

Structure
REQ-026 SHALL place register offset constants and field bit positions in shared package io_pwm_pkg.
REQ-027 SHALL instantiate NCH copies of sub-module io_pwm_chan (duty register, shadow, compare, output flop).

Verification
REQ-028 SHALL verify: PRESCALE 0, PERIOD 9, DUTY0 3, enable -> pwm_out[0] high 3 cycles, low 7, repeating period 10.
REQ-029 SHALL verify: DUTY1 0 -> pwm_out[1] never high; DUTY2 20 with PERIOD 9 -> pwm_out[2] constantly high.
REQ-030 SHALL verify: DUTY0 changed 3->6 mid-period -> current period keeps 3-cycle high, next period 6.
REQ-031 SHALL verify: irq_en 1 -> pwm_irq rises at wrap; W1C on STATUS in same cycle as wrap -> pwm_irq remains 1.
REQ-032 SHALL verify: read offset 2 after reset -> 0x0000FFFF next cycle; non-hit read -> dma_io_rdata equals dma_io_rdata_in.
REQ-033 SHALL verify: rst_n low for one cycle mid-period -> all outputs 0, registers at reset values next cycle.
